// File: rtl/ball_motion_engine.sv
// Multi-ball motion and game-state engine: one shared update datapath serves BALL_NUM balls
// in round-robin turns; DDA accumulators give sub-pixel speed; INIT/WAIT/PLAY/DEAD/OVER FSM with lives.
module ball_motion_engine #(
    parameter int BALL_NUM = 3,
    parameter int MAXX     = 639,
    parameter int MAXY     = 479,
    parameter int UNIT     = 1023,
    parameter int PD_SZ    = 8,
    parameter int PD_HALF  = 32,
    parameter int LIVES    = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    launch,
    input  logic [9:0]              pd_x,
    input  logic [5:0]              radius,
    input  logic [10:0]             speed_x,
    input  logic [10:0]             speed_y,
    output logic [BALL_NUM*10-1:0]  b_x,
    output logic [BALL_NUM*10-1:0]  b_y,
    output logic [BALL_NUM-1:0]     b_alive,
    output logic [2:0]              state,
    output logic [2:0]              lives,
    output logic                    drop,
    output logic                    game_over
);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_PLAY = 3'd2;
    localparam logic [2:0] S_DEAD = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    localparam int          IW        = (BALL_NUM > 1) ? $clog2(BALL_NUM) : 1;
    localparam logic [10:0] MAXX_W    = 11'(MAXX);
    localparam logic [10:0] MAXY_W    = 11'(MAXY);
    localparam logic [10:0] PD_SZ_W   = 11'(PD_SZ);
    localparam logic [10:0] PD_HALF_W = 11'(PD_HALF);
    localparam logic [11:0] UNIT_W    = 12'(UNIT);

    logic [BALL_NUM-1:0] turn;
    logic [9:0]          pos_x [BALL_NUM];
    logic [9:0]          pos_y [BALL_NUM];
    logic [10:0]         acc_x [BALL_NUM];
    logic [10:0]         acc_y [BALL_NUM];
    logic [BALL_NUM-1:0] dir_x;
    logic [BALL_NUM-1:0] dir_y;
    logic [10:0]         spd_x;
    logic [10:0]         spd_y;

    logic [IW-1:0] sel;
    logic [10:0]   r_w, cur_x, cur_y, pd_w, dist_x;
    logic [9:0]    wait_y, npos_x, npos_y;
    logic          cur_dx, cur_dy, nx_dx, nx_dy, falling, upd, step_x, step_y;
    logic [11:0]   sum_x, sum_y;
    logic [10:0]   nacc_x, nacc_y;

    always_comb begin
        sel = '0;
        for (int i = 0; i < BALL_NUM; i++)
            if (turn[i]) sel = IW'(i);
    end

    // Datapath for the ball whose turn it is; all comparisons widened to 11 bits so nothing wraps.
    always_comb begin
        r_w    = {5'd0, radius};
        cur_x  = {1'b0, pos_x[sel]};
        cur_y  = {1'b0, pos_y[sel]};
        pd_w   = {1'b0, pd_x};
        dist_x = (cur_x >= pd_w) ? cur_x - pd_w : pd_w - cur_x;
        cur_dx = dir_x[sel];
        cur_dy = dir_y[sel];

        nx_dx = cur_dx;
        if (cur_dx && cur_x <= r_w)
            nx_dx = 1'b0;
        else if (!cur_dx && cur_x + r_w >= MAXX_W)
            nx_dx = 1'b1;

        nx_dy = cur_dy;
        if (cur_dy && cur_y <= r_w)
            nx_dy = 1'b0;
        else if (!cur_dy && cur_y + r_w >= MAXY_W - PD_SZ_W && cur_y + r_w <= MAXY_W
                 && dist_x <= PD_HALF_W)
            nx_dy = 1'b1;

        sum_x  = {1'b0, acc_x[sel]} + {1'b0, spd_x};
        sum_y  = {1'b0, acc_y[sel]} + {1'b0, spd_y};
        step_x = sum_x >= UNIT_W;
        step_y = sum_y >= UNIT_W;
        nacc_x = step_x ? 11'(sum_x - UNIT_W) : sum_x[10:0];
        nacc_y = step_y ? 11'(sum_y - UNIT_W) : sum_y[10:0];

        npos_x = pos_x[sel];
        if (step_x) npos_x = nx_dx ? pos_x[sel] - 10'd1 : pos_x[sel] + 10'd1;
        npos_y = pos_y[sel];
        if (step_y) npos_y = nx_dy ? pos_y[sel] - 10'd1 : pos_y[sel] + 10'd1;

        falling = cur_y > MAXY_W + r_w;
        wait_y  = 10'(MAXY_W - r_w - PD_SZ_W);
        upd     = enable && (state == S_PLAY) && b_alive[sel];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_INIT;
            lives   <= 3'd0;
            turn    <= BALL_NUM'(1);
            b_alive <= '0;
            drop    <= 1'b0;
            dir_x   <= '0;
            dir_y   <= '0;
            spd_x   <= '0;
            spd_y   <= '0;
            for (int i = 0; i < BALL_NUM; i++) begin
                pos_x[i] <= 10'(MAXX / 2);
                pos_y[i] <= 10'(MAXY / 2);
                acc_x[i] <= '0;
                acc_y[i] <= '0;
            end
        end else begin
            drop <= 1'b0;
            if (enable) turn <= {turn[BALL_NUM-2:0], turn[BALL_NUM-1]};

            case (state)
                S_INIT: begin
                    lives <= 3'(LIVES);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Balls ride on the paddle until launch; odd balls start leftward.
                    for (int i = 0; i < BALL_NUM; i++) begin
                        pos_x[i] <= pd_x;
                        pos_y[i] <= wait_y;
                        dir_y[i] <= 1'b1;
                        dir_x[i] <= ((i % 2) == 1);
                        acc_x[i] <= '0;
                        acc_y[i] <= '0;
                    end
                    if (launch) begin
                        spd_x   <= speed_x;
                        spd_y   <= speed_y;
                        b_alive <= '1;
                        state   <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (b_alive == '0) state <= S_DEAD;
                    if (upd) begin
                        if (falling) begin
                            b_alive[sel] <= 1'b0;
                            drop         <= 1'b1;
                        end else begin
                            dir_x[sel] <= nx_dx;
                            dir_y[sel] <= nx_dy;
                            acc_x[sel] <= nacc_x;
                            acc_y[sel] <= nacc_y;
                            pos_x[sel] <= npos_x;
                            pos_y[sel] <= npos_y;
                        end
                    end
                end
                S_DEAD: begin
                    lives <= lives - 3'd1;
                    state <= (lives == 3'd1) ? S_OVER : S_WAIT;
                end
                S_OVER: begin
                    if (launch) state <= S_INIT;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    for (genvar g = 0; g < BALL_NUM; g++) begin : g_flat
        assign b_x[g*10 +: 10] = pos_x[g];
        assign b_y[g*10 +: 10] = pos_y[g];
    end

    assign game_over = (state == S_OVER);

endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine (two balls): directed scenarios plus random play, all checked against an integer game model.
module tb_ball_motion_engine;

    localparam int NB = 2, MAXX = 639, MAXY = 479, UNIT = 1023, PD_SZ = 8, PD_HALF = 32, LIVES = 3;

    logic        clock = 1'b0, reset = 1'b1, enable = 1'b0, launch = 1'b0;
    logic [9:0]  pd_x = 10'd320;
    logic [5:0]  radius = 6'd4;
    logic [10:0] speed_x = 11'd0, speed_y = 11'd0;
    logic [NB*10-1:0] b_x, b_y;
    logic [NB-1:0]    b_alive;
    logic [2:0]       state, lives;
    logic             drop, game_over;
    logic [49:0]      obs;

    int checks = 0, failures = 0;

    // Game model: plain integers, ball turn kept as an index.
    int m_state, m_lives, m_turn, m_drop, m_sx, m_sy;
    int m_x[NB], m_y[NB], m_ax[NB], m_ay[NB], m_dx[NB], m_dy[NB], m_alive[NB];

    ball_motion_engine #(.BALL_NUM(NB)) dut (
        .clock(clock), .reset(reset), .enable(enable), .launch(launch),
        .pd_x(pd_x), .radius(radius), .speed_x(speed_x), .speed_y(speed_y),
        .b_x(b_x), .b_y(b_y), .b_alive(b_alive), .state(state), .lives(lives),
        .drop(drop), .game_over(game_over)
    );

    always #5 clock = ~clock;

    assign obs = {state, lives, drop, game_over, b_alive, b_x, b_y};

    function automatic logic [49:0] model_vec();
        logic [19:0] vx, vy;
        logic [1:0]  va;
        for (int i = 0; i < NB; i++) begin
            vx[i*10 +: 10] = 10'(m_x[i]);
            vy[i*10 +: 10] = 10'(m_y[i]);
            va[i] = (m_alive[i] != 0);
        end
        return {3'(m_state), 3'(m_lives), (m_drop != 0), (m_state == 4), va, vx, vy};
    endfunction

    task automatic model_ball(input int b);
        int r, x, y, pd, d;
        r = int'(radius); x = m_x[b]; y = m_y[b]; pd = int'(pd_x);
        d = (x > pd) ? x - pd : pd - x;
        if (y > MAXY + r) begin
            m_alive[b] = 0;
            m_drop = 1;
        end else begin
            if (m_dx[b] == 1 && x <= r) m_dx[b] = 0;
            else if (m_dx[b] == 0 && x + r >= MAXX) m_dx[b] = 1;
            if (m_dy[b] == 1 && y <= r) m_dy[b] = 0;
            else if (m_dy[b] == 0 && y + r >= MAXY - PD_SZ && y + r <= MAXY && d <= PD_HALF) m_dy[b] = 1;
            m_ax[b] += m_sx;
            if (m_ax[b] >= UNIT) begin
                m_ax[b] -= UNIT;
                m_x[b] += (m_dx[b] == 1) ? -1 : 1;
            end
            m_ay[b] += m_sy;
            if (m_ay[b] >= UNIT) begin
                m_ay[b] -= UNIT;
                m_y[b] += (m_dy[b] == 1) ? -1 : 1;
            end
        end
    endtask

    task automatic model_step();
        int nstate, any_alive;
        if (reset) begin
            m_state = 0; m_lives = 0; m_turn = 0; m_drop = 0; m_sx = 0; m_sy = 0;
            for (int i = 0; i < NB; i++) begin
                m_x[i] = MAXX / 2; m_y[i] = MAXY / 2; m_ax[i] = 0; m_ay[i] = 0;
                m_dx[i] = 0; m_dy[i] = 0; m_alive[i] = 0;
            end
            return;
        end
        nstate = m_state;
        m_drop = 0;
        any_alive = 0;
        for (int i = 0; i < NB; i++) any_alive |= m_alive[i];
        case (m_state)
            0: begin m_lives = LIVES; nstate = 1; end
            1: begin
                for (int i = 0; i < NB; i++) begin
                    m_x[i] = int'(pd_x); m_y[i] = MAXY - int'(radius) - PD_SZ;
                    m_dy[i] = 1; m_dx[i] = i % 2; m_ax[i] = 0; m_ay[i] = 0;
                end
                if (launch) begin
                    m_sx = int'(speed_x); m_sy = int'(speed_y);
                    for (int i = 0; i < NB; i++) m_alive[i] = 1;
                    nstate = 2;
                end
            end
            2: begin
                if (any_alive == 0) nstate = 3;
                if (enable && m_alive[m_turn] != 0) model_ball(m_turn);
            end
            3: begin
                nstate = (m_lives == 1) ? 4 : 1;
                m_lives = m_lives - 1;
            end
            default: if (launch) nstate = 0;
        endcase
        if (enable) m_turn = (m_turn + 1) % NB;
        m_state = nstate;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; launch = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; launch = 1'b0; pd_x = 10'd320; radius = 6'd4;
        tick(); tick();
        if (state !== 3'd0 || lives !== 3'd0 || b_alive !== 2'b00 || drop !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got st=%0d lv=%0d al=%b dr=%b want 0 0 00 0", state, lives, b_alive, drop);
        end
        checks++;
        if (b_x !== {10'd319, 10'd319} || b_y !== {10'd239, 10'd239}) begin
            failures++; $display("FAIL reset_pos got x=%h y=%h want x=%h y=%h", b_x, b_y, {10'd319, 10'd319}, {10'd239, 10'd239});
        end
        checks++;
        reset = 1'b0;
        tick();
        if (state !== 3'd1 || lives !== 3'd3) begin
            failures++; $display("FAIL init_to_wait got st=%0d lv=%0d want 1 3", state, lives);
        end
        checks++;
        tick();
        if (b_x !== {10'd320, 10'd320} || b_y !== {10'd467, 10'd467}) begin
            failures++; $display("FAIL wait_pos got x=%h y=%h want x=%h y=%h", b_x, b_y, {10'd320, 10'd320}, {10'd467, 10'd467});
        end
        checks++;
        if (obs !== model_vec()) begin
            failures++; $display("FAIL reset_model got=%h exp=%h", obs, model_vec());
        end
        checks++;
    endtask

    task automatic test_launch();
        speed_x = 11'(UNIT); speed_y = 11'(UNIT); launch = 1'b1;
        tick();
        launch = 1'b0;
        if (state !== 3'd2) begin
            failures++; $display("FAIL launch_state got=%0d want=2", state);
        end
        checks++;
        enable = 1'b1;
        tick();
        if (b_x[9:0] !== 10'd321 || b_y[9:0] !== 10'd466 || b_x[19:10] !== 10'd320) begin
            failures++; $display("FAIL ball0_first got x0=%0d y0=%0d x1=%0d want 321 466 320", b_x[9:0], b_y[9:0], b_x[19:10]);
        end
        checks++;
        tick();
        if (b_x[19:10] !== 10'd319 || b_y[19:10] !== 10'd466) begin
            failures++; $display("FAIL ball1_next got x1=%0d y1=%0d want 319 466", b_x[19:10], b_y[19:10]);
        end
        checks++;
    endtask

    task automatic test_wall_bounce();
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (obs !== model_vec()) begin
                failures++; $display("FAIL wall_model cyc=%0d got=%h exp=%h", c, obs, model_vec());
            end
            checks++;
            if (m_x[1] == 4) break;
        end
        if (b_x[19:10] !== 10'd4) begin
            failures++; $display("FAIL wall_reach got=%0d want=4", b_x[19:10]);
        end
        checks++;
        tick(); tick();
        if (b_x[19:10] !== 10'd5) begin
            failures++; $display("FAIL wall_flip got=%0d want=5", b_x[19:10]);
        end
        checks++;
    endtask

    task automatic test_paddle();
        int ndrop;
        do_reset();
        enable = 1'b1; pd_x = 10'd320; radius = 6'd4;
        speed_x = 11'd0; speed_y = 11'(UNIT / 2); launch = 1'b1;
        tick();
        launch = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (obs !== model_vec()) begin
                failures++; $display("FAIL paddle_model cyc=%0d got=%h exp=%h", c, obs, model_vec());
            end
            checks++;
        end
        if (state !== 3'd2 || b_alive !== 2'b11) begin
            failures++; $display("FAIL paddle_hit got st=%0d al=%b want 2 11", state, b_alive);
        end
        checks++;
        pd_x = 10'd360;
        ndrop = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (drop) ndrop++;
            if (obs !== model_vec()) begin
                failures++; $display("FAIL miss_model cyc=%0d got=%h exp=%h", c, obs, model_vec());
            end
            checks++;
        end
        if (ndrop != 2 || state !== 3'd1 || lives !== 3'd2 || b_alive !== 2'b00) begin
            failures++; $display("FAIL paddle_miss got drops=%0d st=%0d lv=%0d al=%b want 2 1 2 00", ndrop, state, lives, b_alive);
        end
        checks++;
    endtask

    task automatic test_drop_to_over();
        int ndrop, ndead;
        do_reset();
        enable = 1'b1; radius = 6'd4; speed_x = 11'd0; speed_y = 11'(UNIT);
        ndrop = 0; ndead = 0;
        for (int c = 0; c < 12000; c++) begin
            if (m_state == 1) begin pd_x = 10'd320; launch = 1'b1; end
            else begin pd_x = 10'd0; launch = 1'b0; end
            tick();
            if (drop) ndrop++;
            if (state == 3'd3) ndead++;
            if (obs !== model_vec()) begin
                failures++; $display("FAIL drop_model cyc=%0d got=%h exp=%h", c, obs, model_vec());
            end
            checks++;
            if (m_state == 4) break;
        end
        launch = 1'b0;
        if (ndrop != 6 || ndead != 3) begin
            failures++; $display("FAIL drop_count got drops=%0d dead=%0d want 6 3", ndrop, ndead);
        end
        checks++;
        if (state !== 3'd4 || game_over !== 1'b1 || lives !== 3'd0) begin
            failures++; $display("FAIL game_over got st=%0d go=%b lv=%0d want 4 1 0", state, game_over, lives);
        end
        checks++;
        launch = 1'b1;
        tick();
        launch = 1'b0;
        if (state !== 3'd0 || game_over !== 1'b0) begin
            failures++; $display("FAIL restart got st=%0d go=%b want 0 0", state, game_over);
        end
        checks++;
        tick();
        if (state !== 3'd1 || lives !== 3'd3) begin
            failures++; $display("FAIL reload got st=%0d lv=%0d want 1 3", state, lives);
        end
        checks++;
    endtask

    task automatic test_enable_hold();
        logic [49:0] snap;
        do_reset();
        enable = 1'b1; pd_x = 10'($urandom_range(100, 500)); radius = 6'($urandom_range(0, 20));
        speed_x = 11'($urandom_range(1, UNIT)); speed_y = 11'($urandom_range(1, UNIT)); launch = 1'b1;
        tick();
        launch = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        snap = model_vec();
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (obs !== snap) begin
                failures++; $display("FAIL hold cyc=%0d got=%h exp=%h", c, obs, snap);
            end
            checks++;
        end
        enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (obs !== model_vec()) begin
                failures++; $display("FAIL resume cyc=%0d got=%h exp=%h", c, obs, model_vec());
            end
            checks++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            reset   = ($urandom_range(0, 999) == 0);
            enable  = ($urandom_range(0, 3) != 0);
            launch  = ($urandom_range(0, 39) == 0);
            if (c % 64 == 0) begin
                pd_x   = 10'($urandom_range(0, MAXX));
                radius = 6'($urandom);
            end
            speed_x = 11'($urandom_range(0, UNIT));
            speed_y = 11'($urandom_range(0, UNIT));
            tick();
            if (obs !== model_vec()) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, model_vec());
            end
            checks++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_wall_bounce();
        test_paddle();
        test_drop_to_over();
        test_enable_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Parametrised multi-ball motion and game-state engine for the Arkanoid datapath, successor to the single-ball state control.
- Time-multiplexes BALL_NUM balls over one update datapath (round-robin turn). Uses DDA accumulators for sub-pixel speed.
- Handles wall/ceiling/paddle bounce and drop detection, and runs the INIT/WAIT/PLAY/DEAD/OVER game FSM with a lives counter.
- Sits between paddle control and the VGA renderer; block collision is handled elsewhere.

Parameters:
- BALL_NUM, 3, number of balls (>=2).
- MAXX, 639, rightmost pixel column.
- MAXY, 479, bottom pixel row.
- UNIT, 1023, DDA modulus; speed value UNIT = 1 pixel per ball turn.
- PD_SZ, 8, paddle thickness in pixels.
- PD_HALF, 32, paddle half-width in pixels.
- LIVES, 3, lives loaded in INIT (1..7).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  motion tick; balls update only when high
- launch  in  1  start play from WAIT; restart from OVER
- pd_x  in  10  paddle centre column
- radius  in  6  ball radius, shared by all balls
- speed_x  in  11  x speed, sampled at launch (0..UNIT)
- speed_y  in  11  y speed, sampled at launch (0..UNIT)
- b_x  out  BALL_NUM*10  flattened ball x; ball i at [i*10+:10]
- b_y  out  BALL_NUM*10  flattened ball y
- b_alive  out  BALL_NUM  per-ball alive flags
- state  out  3  INIT=0, WAIT=1, PLAY=2, DEAD=3, OVER=4
- lives  out  3  remaining lives
- drop  out  1  one-cycle pulse when any ball falls out
- game_over  out  1  high while in OVER

Behaviour:
Reset:
- state=INIT, lives=0, turn=one-hot bit0, b_alive=0, drop=0.
- All b_x=MAXX/2, b_y=MAXY/2; all accumulators 0; dir_x/dir_y=0.
- dir=1 means negative direction (left/up).

FSM (advances every clock, independent of enable):
- INIT: lives<=LIVES; next WAIT.
- WAIT: every cycle, each ball is set to b_x=pd_x, b_y=MAXY-radius-PD_SZ, dir_y=1, dir_x = i odd ? 1 : 0, accumulators 0. On launch: latch speed_x/speed_y, set b_alive all 1, next PLAY.
- PLAY: if b_alive==0 (checked on registered value), next DEAD. launch is ignored.
- DEAD: lives<=lives-1. If lives==1, next OVER; else next WAIT. Lasts exactly 1 cycle.
- OVER: game_over=1; launch -> INIT.

Turn:
- When enable=1, turn rotates left one bit per clock; when enable=0, turn holds.
- Ball i updates only when enable && turn[i] && b_alive[i] && state==PLAY.

Ball update (single cycle, ball i), evaluated on current registered position:
1. Bounce flips:
   - x<=radius and dir_x=1 -> dir_x=0.
   - x+radius>=MAXX and dir_x=0 -> dir_x=1.
   - y<=radius and dir_y=1 -> dir_y=0.
   - Paddle: dir_y=0, y+radius>=MAXY-PD_SZ, y+radius<=MAXY, and |x-pd_x|<=PD_HALF -> dir_y=1.
   - All comparisons are unsigned 11-bit to avoid wrap.
2. DDA step, using the new direction from step 1:
   - acc_x+speed_x>=UNIT -> acc_x<=acc_x+speed_x-UNIT, x steps 1 pixel in dir_x.
   - Otherwise acc_x<=acc_x+speed_x.
   - Same rule for y.
3. Drop: if y>MAXY+radius before the step, clear b_alive[i], pulse drop next cycle; no step is applied.

Edge cases:
- Speed 0 freezes that axis.
- x/y never wrap past 0 because the flip precedes the step.
- Multiple drops in one cycle are impossible (one ball per cycle).
- Dead balls hold their last position.
- Reset mid-play restores all reset values on the next edge.

Test Plan:
- Reset, BALL_NUM=2, pd_x=320, radius=4 -> INIT for 1 cycle, then WAIT; lives=3. Both balls at (320,467); dir_x of ball0=0, ball1=1.
- launch, speed_x=speed_y=UNIT, enable=1 -> PLAY. Ball0 at (321,466) after its first turn. Ball1 at (319,466) one cycle later.
- Ball at x=5, radius=4, dir_x=1, speed_x=UNIT -> x=4. On the next turn dir_x flips to 0 and x=5; no underflow.
- speed_y=UNIT/2, ball moving down, pd_x aligned -> y steps every second turn. At y+radius=471, dir_y flips to 1. With pd_x offset by 40 there is no flip.
- pd_x=0, all balls fall -> each ball loses alive with one drop pulse; DEAD for 1 cycle; lives=2; WAIT. After three losses -> OVER, game_over=1. launch -> INIT.
- Hold enable=0 in PLAY for 20 cycles -> positions, accumulators and turn unchanged. Resuming enable continues from the same ball.
